// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// datapath mux codes and the packed control word produced per state.
package mips_ctrl_pkg;

    localparam int unsigned ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_RTEX      = 4'd2,
        S_RTWB      = 4'd3,
        S_IMMEX_ADD = 4'd4,
        S_IMMEX_AND = 4'd5,
        S_IWB       = 4'd6,
        S_MEMADR    = 4'd7,
        S_MEMRD     = 4'd8,
        S_MEMWB     = 4'd9,
        S_MEMWR     = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14,
        S_TRAP      = 4'd15
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_A      = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // pc_write/ir_write/done are qualified by mem_ready when mem_wait is set;
    // branch requests a pc_write conditioned on the zero flag.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       done;
        logic       mem_wait;
    } ctrl_word_t;

    function automatic ctrl_word_t cw_idle();
        ctrl_word_t cw;
        cw = '0;
        return cw;
    endfunction

endpackage

// File: rtl/ctrl_word_rom.sv
// Purely combinational state -> control word table for the multicycle controller.
module ctrl_word_rom
    import mips_ctrl_pkg::*;
(
    input  logic [ST_W-1:0] state_i,
    output ctrl_word_t      cw_o
);

    // Per-state control word lookup; unlisted fields stay at zero.
    always_comb begin
        cw_o = cw_idle();
        case (state_i)
            S_FETCH: begin
                cw_o.mem_read  = 1'b1;
                cw_o.ir_write  = 1'b1;
                cw_o.pc_write  = 1'b1;
                cw_o.mem_wait  = 1'b1;
                cw_o.alu_src_b = SRCB_FOUR;
                cw_o.alu_op    = ALUOP_ADD;
                cw_o.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                cw_o.alu_src_b = SRCB_IMM_SH;
            end
            S_RTEX: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_B;
                cw_o.alu_op    = ALUOP_FUNCT;
            end
            S_RTWB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.reg_dst    = REGDST_RD;
                cw_o.mem_to_reg = M2R_ALUOUT;
                cw_o.done       = 1'b1;
            end
            S_IMMEX_ADD, S_MEMADR: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_IMM;
            end
            S_IMMEX_AND: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_IMM;
                cw_o.alu_op    = ALUOP_AND;
            end
            S_IWB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.reg_dst    = REGDST_RT;
                cw_o.mem_to_reg = M2R_ALUOUT;
                cw_o.done       = 1'b1;
            end
            S_MEMRD: begin
                cw_o.mem_read = 1'b1;
                cw_o.iord     = 1'b1;
                cw_o.mem_wait = 1'b1;
            end
            S_MEMWB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.reg_dst    = REGDST_RT;
                cw_o.mem_to_reg = M2R_MDR;
                cw_o.done       = 1'b1;
            end
            S_MEMWR: begin
                cw_o.mem_write = 1'b1;
                cw_o.iord      = 1'b1;
                cw_o.done      = 1'b1;
                cw_o.mem_wait  = 1'b1;
            end
            S_BRANCH: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_B;
                cw_o.alu_op    = ALUOP_SUB;
                cw_o.pc_src    = PCSRC_ALUOUT;
                cw_o.branch    = 1'b1;
                cw_o.done      = 1'b1;
            end
            S_JUMP: begin
                cw_o.pc_src   = PCSRC_JUMP;
                cw_o.pc_write = 1'b1;
                cw_o.done     = 1'b1;
            end
            S_JAL: begin
                cw_o.pc_src     = PCSRC_JUMP;
                cw_o.pc_write   = 1'b1;
                cw_o.reg_write  = 1'b1;
                cw_o.reg_dst    = REGDST_RA;
                cw_o.mem_to_reg = M2R_PC;
                cw_o.done       = 1'b1;
            end
            S_JR: begin
                cw_o.pc_src   = PCSRC_A;
                cw_o.pc_write = 1'b1;
                cw_o.done     = 1'b1;
            end
            S_TRAP: begin
                cw_o = cw_idle();
            end
            default: begin
                cw_o = cw_idle();
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset main controller. Define MC_ILLEGAL_TRAP_EN to send
// unrecognised opcodes to an absorbing TRAP state; otherwise they retire as NOPs.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4,
    parameter int unsigned ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rt,
    input  logic               addi,
    input  logic               andi,
    input  logic               lw,
    input  logic               sw,
    input  logic               j,
    input  logic               jal,
    input  logic               jr,
    input  logic               beq,
    input  logic               bne,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_src,
    output logic               instr_done,
    output logic               illegal
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               is_bne_q, is_bne_d;
    logic               illegal_q, illegal_d;
    ctrl_word_t         cw_s;
    logic               any_class_s;
    logic               ready_gate_s;
    logic               branch_take_s;
    logic               nop_done_s;

    ctrl_word_rom u_rom (
        .state_i (state_q),
        .cw_o    (cw_s)
    );

    assign any_class_s = rt | addi | andi | lw | sw | j | jal | jr | beq | bne;

    // Next-state, branch-sense latch and sticky illegal flag.
    always_comb begin
        state_d  = state_q;
        is_bne_d = is_bne_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                is_bne_d = bne;
                if (rt) begin
                    state_d = S_RTEX;
                end else if (addi) begin
                    state_d = S_IMMEX_ADD;
                end else if (andi) begin
                    state_d = S_IMMEX_AND;
                end else if (lw | sw) begin
                    state_d = S_MEMADR;
                end else if (j) begin
                    state_d = S_JUMP;
                end else if (jal) begin
                    state_d = S_JAL;
                end else if (jr) begin
                    state_d = S_JR;
                end else if (beq | bne) begin
                    state_d = S_BRANCH;
                end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_RTEX:                   state_d = S_RTWB;
            S_IMMEX_ADD, S_IMMEX_AND: state_d = S_IWB;
            S_MEMADR: begin
                if (lw) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWR;
                end
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:                   state_d = S_TRAP;
`endif
            default:                  state_d = S_FETCH;
        endcase
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_d = illegal_q | (state_d == S_TRAP);
`else
        illegal_d = 1'b0;
`endif
    end

    // State and latch registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            is_bne_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_bne_q  <= is_bne_d;
            illegal_q <= illegal_d;
        end
    end

    assign ready_gate_s  = ~cw_s.mem_wait | mem_ready;
    assign branch_take_s = is_bne_q ? ~zero : zero;
`ifdef MC_ILLEGAL_TRAP_EN
    assign nop_done_s    = 1'b0;
`else
    assign nop_done_s    = (state_q == S_DECODE) & ~any_class_s;
`endif

    // Output drive: rst_n forces everything low without waiting for a clock.
    always_comb begin
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = '0;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            pc_write   = (cw_s.pc_write & ready_gate_s) | (cw_s.branch & branch_take_s);
            iord       = cw_s.iord;
            mem_read   = cw_s.mem_read;
            mem_write  = cw_s.mem_write;
            ir_write   = cw_s.ir_write & ready_gate_s;
            reg_write  = cw_s.reg_write;
            reg_dst    = cw_s.reg_dst;
            mem_to_reg = cw_s.mem_to_reg;
            alu_src_a  = cw_s.alu_src_a;
            alu_src_b  = cw_s.alu_src_b;
            alu_op     = ALUOP_W'(cw_s.alu_op);
            pc_src     = cw_s.pc_src;
            instr_done = (cw_s.done & ready_gate_s) | nop_done_s;
            illegal    = illegal_q;
        end else begin
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle output
// expectations and instruction latencies, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic rt, addi, andi, lw, sw, j, jal, jr, beq, bne;
    logic zero, mem_ready;
    logic pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
    logic alu_src_a, instr_done, illegal;

    multicycle_ctrl #(.STATE_W(4), .ALUOP_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rt(rt), .addi(addi), .andi(andi), .lw(lw), .sw(sw),
        .j(j), .jal(jal), .jr(jr), .beq(beq), .bne(bne),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {pc_write,iord,mem_read,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,
    //  alu_src_a,alu_src_b,alu_op,pc_src,instr_done,illegal}
    logic [18:0] act;
    assign act = {pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal};

    localparam logic [18:0] V_ZERO      = 19'b0_0_0_0_0_0_00_00_0_00_00_00_0_0;
    localparam logic [18:0] V_FETCH_W   = 19'b0_0_1_0_0_0_00_00_0_01_00_00_0_0;
    localparam logic [18:0] V_FETCH_R   = 19'b1_0_1_0_1_0_00_00_0_01_00_00_0_0;
    localparam logic [18:0] V_DECODE    = 19'b0_0_0_0_0_0_00_00_0_11_00_00_0_0;
    localparam logic [18:0] V_DECODE_NOP= 19'b0_0_0_0_0_0_00_00_0_11_00_00_1_0;
    localparam logic [18:0] V_RTEX      = 19'b0_0_0_0_0_0_00_00_1_00_10_00_0_0;
    localparam logic [18:0] V_RTWB      = 19'b0_0_0_0_0_1_01_00_0_00_00_00_1_0;
    localparam logic [18:0] V_IMM_ADD   = 19'b0_0_0_0_0_0_00_00_1_10_00_00_0_0;
    localparam logic [18:0] V_IMM_AND   = 19'b0_0_0_0_0_0_00_00_1_10_11_00_0_0;
    localparam logic [18:0] V_IWB       = 19'b0_0_0_0_0_1_00_00_0_00_00_00_1_0;
    localparam logic [18:0] V_MEMADR    = 19'b0_0_0_0_0_0_00_00_1_10_00_00_0_0;
    localparam logic [18:0] V_MEMRD     = 19'b0_1_1_0_0_0_00_00_0_00_00_00_0_0;
    localparam logic [18:0] V_MEMWB     = 19'b0_0_0_0_0_1_00_01_0_00_00_00_1_0;
    localparam logic [18:0] V_MEMWR_W   = 19'b0_1_0_1_0_0_00_00_0_00_00_00_0_0;
    localparam logic [18:0] V_MEMWR_R   = 19'b0_1_0_1_0_0_00_00_0_00_00_00_1_0;
    localparam logic [18:0] V_BR_T      = 19'b1_0_0_0_0_0_00_00_1_00_01_01_1_0;
    localparam logic [18:0] V_BR_N      = 19'b0_0_0_0_0_0_00_00_1_00_01_01_1_0;
    localparam logic [18:0] V_JUMP      = 19'b1_0_0_0_0_0_00_00_0_00_00_10_1_0;
    localparam logic [18:0] V_JAL       = 19'b1_0_0_0_0_1_10_10_0_00_00_10_1_0;
    localparam logic [18:0] V_JR        = 19'b1_0_0_0_0_0_00_00_0_00_00_11_1_0;
    localparam logic [18:0] V_TRAP      = 19'b0_0_0_0_0_0_00_00_0_00_00_00_0_1;

    // class vector order {rt,addi,andi,lw,sw,j,jal,jr,beq,bne}
    localparam logic [9:0] C_NONE = 10'b00_0000_0000;
    localparam logic [9:0] C_RT   = 10'b10_0000_0000;
    localparam logic [9:0] C_ADDI = 10'b01_0000_0000;
    localparam logic [9:0] C_ANDI = 10'b00_1000_0000;
    localparam logic [9:0] C_LW   = 10'b00_0100_0000;
    localparam logic [9:0] C_SW   = 10'b00_0010_0000;
    localparam logic [9:0] C_J    = 10'b00_0001_0000;
    localparam logic [9:0] C_JAL  = 10'b00_0000_1000;
    localparam logic [9:0] C_JR   = 10'b00_0000_0100;
    localparam logic [9:0] C_BEQ  = 10'b00_0000_0010;
    localparam logic [9:0] C_BNE  = 10'b00_0000_0001;

    typedef struct { string nm; logic [18:0] v; } exp_t;
    typedef struct { string nm; int lat; } lat_t;
    exp_t exp_q[$];
    lat_t lat_q[$];
    exp_t e;
    lat_t l;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    bit   stim_done = 1'b0;

    task automatic set_cls(input logic [9:0] c);
        {rt, addi, andi, lw, sw, j, jal, jr, beq, bne} = c;
    endtask

    task automatic expect_lat(input string nm, input int n);
        lat_q.push_back('{nm, n});
    endtask

    task automatic step(input string nm, input logic [18:0] v, input logic rdy, input logic z);
        mem_ready = rdy;
        zero      = z;
        exp_q.push_back('{nm, v});
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        step("reset", V_ZERO, 1'b1, 1'b0);
        step("reset", V_ZERO, 1'b1, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic branch3(input string nm, input logic [9:0] c, input logic z, input logic [18:0] v);
        set_cls(c);
        expect_lat(nm, 3);
        step({nm, "_fetch"}, V_FETCH_R, 1'b1, 1'b0);
        step({nm, "_decode"}, V_DECODE, 1'b1, 1'b0);
        step({nm, "_exec"}, v, 1'b1, z);
    endtask

    // Monitor: per-cycle output compare plus instr_done latency scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: outputs got %b expected %b", e.nm, act, e.v);
            end
        end
        if (rst_n !== 1'b1) begin
            cyc_cnt = 0;
        end else begin
            cyc_cnt++;
            if (instr_done === 1'b1) begin
                checks++;
                if (lat_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: latency got %0d expected no done", cyc_cnt);
                end else begin
                    l = lat_q.pop_front();
                    if (cyc_cnt != l.lat) begin
                        errors++;
                        $display("FAIL %s_latency: got %0d expected %0d", l.nm, cyc_cnt, l.lat);
                    end
                end
                cyc_cnt = 0;
            end
        end
        if (stim_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL leftover_outputs: got %0d pending expected 0", exp_q.size());
            end
            checks++;
            if (lat_q.size() != 0) begin
                errors++;
                $display("FAIL missing_done: got %0d pending expected 0", lat_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        zero = 1'b0;
        mem_ready = 1'b0;
        set_cls(C_NONE);
        @(posedge clk);
        #1;
        reset_seq();

        // lw, memory always ready: 5 cycles
        set_cls(C_LW);
        expect_lat("lw", 5);
        step("lw_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("lw_decode", V_DECODE, 1'b1, 1'b0);
        step("lw_memadr", V_MEMADR, 1'b1, 1'b0);
        step("lw_memrd", V_MEMRD, 1'b1, 1'b0);
        step("lw_memwb", V_MEMWB, 1'b1, 1'b0);

        // sw with three wait cycles in MEMWR: 7 cycles
        set_cls(C_SW);
        expect_lat("sw_wait", 7);
        step("sw_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("sw_decode", V_DECODE, 1'b1, 1'b0);
        step("sw_memadr", V_MEMADR, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("sw_memwr_wait", V_MEMWR_W, 1'b0, 1'b0);
        step("sw_memwr_rdy", V_MEMWR_R, 1'b1, 1'b0);

        // R-type with two fetch wait cycles, mem_ready low elsewhere
        set_cls(C_RT);
        expect_lat("rt_fwait", 6);
        step("rt_fetch_wait", V_FETCH_W, 1'b0, 1'b0);
        step("rt_fetch_wait", V_FETCH_W, 1'b0, 1'b0);
        step("rt_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("rt_decode", V_DECODE, 1'b0, 1'b0);
        step("rt_ex", V_RTEX, 1'b0, 1'b0);
        step("rt_wb", V_RTWB, 1'b0, 1'b0);

        set_cls(C_ADDI);
        expect_lat("addi", 4);
        step("addi_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("addi_decode", V_DECODE, 1'b0, 1'b0);
        step("addi_ex", V_IMM_ADD, 1'b0, 1'b0);
        step("addi_wb", V_IWB, 1'b0, 1'b0);

        set_cls(C_ANDI);
        expect_lat("andi", 4);
        step("andi_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("andi_decode", V_DECODE, 1'b1, 1'b0);
        step("andi_ex", V_IMM_AND, 1'b1, 1'b0);
        step("andi_wb", V_IWB, 1'b1, 1'b0);

        // priority: rt beats lw and beq; addi beats andi
        set_cls(C_RT | C_LW | C_BEQ);
        expect_lat("prio_rt", 4);
        step("prio_rt_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("prio_rt_decode", V_DECODE, 1'b1, 1'b0);
        step("prio_rt_ex", V_RTEX, 1'b1, 1'b0);
        step("prio_rt_wb", V_RTWB, 1'b1, 1'b0);
        set_cls(C_ADDI | C_ANDI);
        expect_lat("prio_addi", 4);
        step("prio_addi_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("prio_addi_decode", V_DECODE, 1'b1, 1'b0);
        step("prio_addi_ex", V_IMM_ADD, 1'b1, 1'b0);
        step("prio_addi_wb", V_IWB, 1'b1, 1'b0);

        branch3("bne_z0", C_BNE, 1'b0, V_BR_T);
        branch3("bne_z1", C_BNE, 1'b1, V_BR_N);
        branch3("beq_z0", C_BEQ, 1'b0, V_BR_N);
        branch3("beq_z1", C_BEQ, 1'b1, V_BR_T);
        branch3("j", C_J, 1'b0, V_JUMP);
        branch3("jal", C_JAL, 1'b0, V_JAL);
        branch3("jr", C_JR, 1'b1, V_JR);

        // lw with two read wait cycles: 7 cycles
        set_cls(C_LW);
        expect_lat("lw_wait", 7);
        step("lw2_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("lw2_decode", V_DECODE, 1'b0, 1'b0);
        step("lw2_memadr", V_MEMADR, 1'b0, 1'b0);
        step("lw2_memrd_wait", V_MEMRD, 1'b0, 1'b0);
        step("lw2_memrd_wait", V_MEMRD, 1'b0, 1'b0);
        step("lw2_memrd_rdy", V_MEMRD, 1'b1, 1'b0);
        step("lw2_memwb", V_MEMWB, 1'b0, 1'b0);

        // no class line asserted
        set_cls(C_NONE);
`ifdef MC_ILLEGAL_TRAP_EN
        step("ill_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("ill_decode", V_DECODE, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            set_cls((i % 2 == 0) ? C_LW : C_J);
            step("trap_hold", V_TRAP, i[0], i[1]);
        end
`else
        expect_lat("nop", 2);
        step("nop_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("nop_decode", V_DECODE_NOP, 1'b1, 1'b0);
        step("nop_next_fetch", V_FETCH_W, 1'b0, 1'b0);
`endif
        reset_seq();
        step("post_ill_fetch", V_FETCH_W, 1'b0, 1'b0);

        // reset asserted mid-wait in MEMWR
        set_cls(C_SW);
        expect_lat("ill_recover_sw_first_part", 0);
        void'(lat_q.pop_back());
        step("rst_sw_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("rst_sw_decode", V_DECODE, 1'b1, 1'b0);
        step("rst_sw_memadr", V_MEMADR, 1'b1, 1'b0);
        step("rst_sw_memwr_wait", V_MEMWR_W, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        exp_q.push_back('{"rst_async", V_ZERO});
        @(posedge clk);
        #1;
        step("rst_hold", V_ZERO, 1'b1, 1'b0);
        rst_n = 1'b1;
        expect_lat("post_rst_sw_then_j", 6);
        for (int i = 0; i < 3; i++) step("post_rst_fetch_wait", V_FETCH_W, 1'b0, 1'b0);
        set_cls(C_J);
        step("post_rst_fetch", V_FETCH_R, 1'b1, 1'b0);
        step("post_rst_decode", V_DECODE, 1'b1, 1'b0);
        step("post_rst_jump", V_JUMP, 1'b1, 1'b0);

        stim_done = 1'b1;
    end

endmodule
